// File: rtl/ulpi_link_arbiter_if.sv
// Requester-side handshake bundle for ulpi_link_arbiter: PHY register access port and PID transmit port.
// master = requesters (config sequencer / protocol engine), slave = arbiter.
interface ulpi_link_arbiter_if;
   logic       reg_req;
   logic       reg_we;
   logic [5:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_ack;
   logic [7:0] reg_rdata;
   logic       reg_err;
   logic       tx_req;
   logic [3:0] tx_pid;
   logic       tx_ack;
   logic       tx_err;

   modport master (
      output reg_req, reg_we, reg_addr, reg_wdata, tx_req, tx_pid,
      input  reg_ack, reg_rdata, reg_err, tx_ack, tx_err
   );

   modport slave (
      input  reg_req, reg_we, reg_addr, reg_wdata, tx_req, tx_pid,
      output reg_ack, reg_rdata, reg_err, tx_ack, tx_err
   );
endinterface

// File: rtl/ulpi_link_arbiter.sv
// Arbitrates the ULPI link->PHY transmit path between register accesses and handshake PIDs.
// Define ULPI_ARB_TIMEOUT_EN to abandon transfers after TIMEOUT cycles in any wait state.
module ulpi_link_arbiter #(
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic              CLKOUT,
   input  logic              RESET,
   input  logic              DIR,
   input  logic              NXT,
   input  logic [7:0]        ulpi_din,
   output logic [7:0]        ulpi_dout,
   output logic              STP,
   output logic              busy,
   ulpi_link_arbiter_if.slave link
);

   typedef enum logic [3:0] {
      IDLE, REG_CMD, REG_DATA, REG_STP, TURN1, RDATA, TURN2, TX_CMD, TX_STP, ERR_STP
   } state_t;

   typedef enum logic {GRANT_REG, GRANT_TX} grant_t;

   state_t     state, next_state;
   grant_t     last_grant;
   logic       rd_retry;
   logic       fin, fin_err;
   logic       capture, preempt;
   logic       to_hit;
   logic       turn1_fail;

   logic [7:0] dout_nxt;
   logic       stp_nxt;
   logic       reg_ack_nxt, reg_err_nxt, tx_ack_nxt, tx_err_nxt;

   logic       reg_ack_q, reg_err_q, tx_ack_q, tx_err_q;
   logic [7:0] reg_rdata_q;

`ifdef ULPI_ARB_TIMEOUT_EN
   logic [15:0] wait_cnt;

   assign to_hit     = (wait_cnt == 16'(TIMEOUT - 1));
   assign turn1_fail = to_hit;

   // Counter restarts on every state change, so each wait state gets a full budget.
   always_ff @(posedge CLKOUT) begin
      if (!RESET || next_state != state || next_state == IDLE)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + 16'd1;
   end
`else
   localparam int unsigned timeout_unused = TIMEOUT;

   assign to_hit     = 1'b0;
   assign turn1_fail = 1'b1;
`endif

   always_ff @(posedge CLKOUT) begin
      if (!RESET) begin
         state       <= IDLE;
         last_grant  <= GRANT_TX;
         rd_retry    <= 1'b0;
         ulpi_dout   <= '0;
         STP         <= 1'b0;
         busy        <= 1'b0;
         reg_ack_q   <= 1'b0;
         reg_err_q   <= 1'b0;
         tx_ack_q    <= 1'b0;
         tx_err_q    <= 1'b0;
         reg_rdata_q <= '0;
      end else begin
         state     <= next_state;
         ulpi_dout <= dout_nxt;
         STP       <= stp_nxt;
         busy      <= (next_state != IDLE);
         reg_ack_q <= reg_ack_nxt;
         reg_err_q <= reg_err_nxt;
         tx_ack_q  <= tx_ack_nxt;
         tx_err_q  <= tx_err_nxt;
         if (state == IDLE && next_state == REG_CMD)
            last_grant <= GRANT_REG;
         else if (state == IDLE && next_state == TX_CMD)
            last_grant <= GRANT_TX;
         if (state == IDLE)
            rd_retry <= 1'b0;
         else if (preempt)
            rd_retry <= 1'b1;
         if (capture)
            reg_rdata_q <= ulpi_din;
      end
   end

   always_comb begin
      next_state = state;
      fin        = 1'b0;
      fin_err    = 1'b0;
      capture    = 1'b0;
      preempt    = 1'b0;
      unique case (state)
         IDLE: begin
            // The ack-high check guarantees at least one idle cycle between grants.
            if (!DIR && !NXT && !reg_ack_q && !tx_ack_q) begin
               if (link.reg_req && (!link.tx_req || last_grant == GRANT_TX))
                  next_state = REG_CMD;
               else if (link.tx_req)
                  next_state = TX_CMD;
            end
         end
         REG_CMD: begin
            if (DIR)
               next_state = IDLE;
            else if (NXT)
               next_state = link.reg_we ? REG_DATA : TURN1;
            else if (to_hit) begin
               if (link.reg_we)
                  next_state = ERR_STP;
               else begin
                  next_state = IDLE;
                  fin        = 1'b1;
                  fin_err    = 1'b1;
               end
            end
         end
         REG_DATA: begin
            if (DIR)
               next_state = IDLE;
            else if (NXT)
               next_state = REG_STP;
            else if (to_hit)
               next_state = ERR_STP;
         end
         REG_STP: begin
            next_state = IDLE;
            fin        = 1'b1;
         end
         TURN1: begin
            if (DIR)
               next_state = RDATA;
            else if (turn1_fail) begin
               next_state = IDLE;
               fin        = 1'b1;
               fin_err    = 1'b1;
            end
         end
         RDATA: begin
            if (DIR) begin
               next_state = TURN2;
               if (NXT)
                  preempt = 1'b1;
               else
                  capture = 1'b1;
            end else begin
               next_state = IDLE;
               fin        = 1'b1;
               fin_err    = 1'b1;
            end
         end
         TURN2: begin
            // A preempted read leaves quietly; the still-held request is re-granted later.
            if (!DIR) begin
               next_state = IDLE;
               fin        = !rd_retry;
            end else if (to_hit) begin
               next_state = IDLE;
               fin        = 1'b1;
               fin_err    = 1'b1;
            end
         end
         TX_CMD: begin
            if (DIR)
               next_state = IDLE;
            else if (NXT)
               next_state = TX_STP;
            else if (to_hit)
               next_state = ERR_STP;
         end
         TX_STP: begin
            next_state = IDLE;
            fin        = 1'b1;
         end
         ERR_STP: begin
            next_state = IDLE;
            fin        = 1'b1;
            fin_err    = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      dout_nxt = '0;
      unique case (next_state)
         REG_CMD:  dout_nxt = {(link.reg_we ? 2'b10 : 2'b11), link.reg_addr};
         REG_DATA: dout_nxt = link.reg_wdata;
         TX_CMD:   dout_nxt = {4'h4, link.tx_pid};
         default:  dout_nxt = '0;
      endcase
      stp_nxt     = (next_state inside {REG_STP, TX_STP, ERR_STP});
      reg_ack_nxt = fin && (last_grant == GRANT_REG);
      reg_err_nxt = fin_err && (last_grant == GRANT_REG);
      tx_ack_nxt  = fin && (last_grant == GRANT_TX);
      tx_err_nxt  = fin_err && (last_grant == GRANT_TX);
   end

   assign link.reg_ack   = reg_ack_q;
   assign link.reg_err   = reg_err_q;
   assign link.reg_rdata = reg_rdata_q;
   assign link.tx_ack    = tx_ack_q;
   assign link.tx_err    = tx_err_q;

endmodule

// File: tb/tb_ulpi_link_arbiter.sv
// Directed bench for ulpi_link_arbiter: reset, arbitration, write, read, abort, mid-transfer reset,
// plus the TURN1 protocol error (default build) or NXT timeout (ULPI_ARB_TIMEOUT_EN).
module tb_ulpi_link_arbiter;

   logic       CLKOUT = 1'b0;
   logic       RESET;
   logic       DIR;
   logic       NXT;
   logic [7:0] ulpi_din;
   logic [7:0] ulpi_dout;
   logic       STP;
   logic       busy;

   int n_checks;
   int n_fail;

   ulpi_link_arbiter_if bus ();

   ulpi_link_arbiter #(.TIMEOUT(8)) dut (
      .CLKOUT    (CLKOUT),
      .RESET     (RESET),
      .DIR       (DIR),
      .NXT       (NXT),
      .ulpi_din  (ulpi_din),
      .ulpi_dout (ulpi_dout),
      .STP       (STP),
      .busy      (busy),
      .link      (bus)
   );

   always #8 CLKOUT = ~CLKOUT;

   task automatic step();
      @(posedge CLKOUT);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      RESET = 1'b0; DIR = 1'b0; NXT = 1'b0; ulpi_din = '0;
      bus.reg_req = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
      bus.tx_req = 1'b0; bus.tx_pid = '0;

      step(); step();
      chk("rst_dout", ulpi_dout, 8'h00);
      chk("rst_stp", STP, 0);
      chk("rst_busy", busy, 0);
      chk("rst_reg_ack", bus.reg_ack, 0);
      chk("rst_tx_ack", bus.tx_ack, 0);
      chk("rst_reg_err", bus.reg_err, 0);
      chk("rst_tx_err", bus.tx_err, 0);
      chk("rst_rdata", bus.reg_rdata, 8'h00);
      RESET = 1'b1;
      step();

      // Simultaneous requests: register wins first, then TX, then register again.
      bus.reg_req = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = 6'h05; bus.reg_wdata = 8'h3C;
      bus.tx_req = 1'b1; bus.tx_pid = 4'h2;
      step(); chk("arb1_cmd", ulpi_dout, 8'h85); chk("arb1_busy", busy, 1); NXT = 1'b1;
      step(); chk("arb1_data", ulpi_dout, 8'h3C);
      step(); chk("arb1_stp", STP, 1); NXT = 1'b0;
      step(); chk("arb1_reg_ack", bus.reg_ack, 1); chk("arb1_tx_ack", bus.tx_ack, 0); chk("arb1_stp_low", STP, 0);
      step(); chk("arb_gap1_busy", busy, 0); chk("arb_gap1_dout", ulpi_dout, 8'h00);
      step(); chk("arb2_cmd", ulpi_dout, 8'h42); NXT = 1'b1;
      step(); chk("arb2_stp", STP, 1); NXT = 1'b0;
      step(); chk("arb2_tx_ack", bus.tx_ack, 1); chk("arb2_tx_err", bus.tx_err, 0); chk("arb2_reg_ack", bus.reg_ack, 0);
      bus.tx_req = 1'b0;
      step(); chk("arb_gap2_busy", busy, 0);
      step(); chk("arb3_cmd", ulpi_dout, 8'h85); NXT = 1'b1;
      step();
      step(); chk("arb3_stp", STP, 1); NXT = 1'b0;
      step(); chk("arb3_reg_ack", bus.reg_ack, 1);
      bus.reg_req = 1'b0;
      step();

      // Register write 0x0A <= 0x00.
      bus.reg_req = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = 6'h0A; bus.reg_wdata = 8'h00;
      step(); chk("wr_cmd", ulpi_dout, 8'h8A); NXT = 1'b1;
      step(); chk("wr_data", ulpi_dout, 8'h00); chk("wr_data_stp", STP, 0); chk("wr_data_busy", busy, 1);
      step(); chk("wr_stp", STP, 1); chk("wr_stp_ack", bus.reg_ack, 0); NXT = 1'b0;
      step(); chk("wr_ack", bus.reg_ack, 1); chk("wr_err", bus.reg_err, 0); chk("wr_stp_low", STP, 0);
      bus.reg_req = 1'b0;
      step(); chk("wr_ack_pulse", bus.reg_ack, 0);

      // Register read 0x00, PHY returns 0x24.
      bus.reg_req = 1'b1; bus.reg_we = 1'b0; bus.reg_addr = 6'h00;
      step(); chk("rd_cmd", ulpi_dout, 8'hC0); NXT = 1'b1;
      step(); chk("rd_turn1_dout", ulpi_dout, 8'h00); chk("rd_turn1_stp", STP, 0); NXT = 1'b0; DIR = 1'b1;
      step(); chk("rd_rdata_stp", STP, 0); chk("rd_rdata_ack", bus.reg_ack, 0); ulpi_din = 8'h24;
      step(); chk("rd_turn2_stp", STP, 0); DIR = 1'b0; ulpi_din = 8'h00;
      step(); chk("rd_ack", bus.reg_ack, 1); chk("rd_err", bus.reg_err, 0); chk("rd_data", bus.reg_rdata, 8'h24);
      chk("rd_ack_stp", STP, 0);
      bus.reg_req = 1'b0;
      step(); chk("rd_data_hold", bus.reg_rdata, 8'h24);

`ifndef ULPI_ARB_TIMEOUT_EN
      // PHY never turns the bus around after the read command.
      bus.reg_req = 1'b1; bus.reg_we = 1'b0; bus.reg_addr = 6'h3F;
      step(); chk("perr_cmd", ulpi_dout, 8'hFF); NXT = 1'b1;
      step(); NXT = 1'b0;
      step(); chk("perr_ack", bus.reg_ack, 1); chk("perr_err", bus.reg_err, 1); chk("perr_stp", STP, 0);
      bus.reg_req = 1'b0;
      step(); chk("perr_err_clear", bus.reg_err, 0);
`endif

      // DIR rises during TX_CMD: abort, then re-issue once the bus is free.
      bus.tx_req = 1'b1; bus.tx_pid = 4'h2;
      step(); chk("abt_cmd", ulpi_dout, 8'h42); DIR = 1'b1;
      step(); chk("abt_dout", ulpi_dout, 8'h00); chk("abt_busy", busy, 0); chk("abt_ack", bus.tx_ack, 0);
      chk("abt_stp", STP, 0);
      step(); chk("abt_hold_busy", busy, 0); chk("abt_hold_ack", bus.tx_ack, 0); DIR = 1'b0;
      step(); chk("abt_reissue", ulpi_dout, 8'h42); NXT = 1'b1;
      step(); chk("abt_stp_pulse", STP, 1); NXT = 1'b0;
      step(); chk("abt_tx_ack", bus.tx_ack, 1); chk("abt_tx_err", bus.tx_err, 0);
      bus.tx_req = 1'b0;
      step();

      // Reset asserted while in REG_DATA.
      bus.reg_req = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = 6'h11; bus.reg_wdata = 8'hA5;
      step(); chk("mrst_cmd", ulpi_dout, 8'h91); NXT = 1'b1;
      step(); chk("mrst_data", ulpi_dout, 8'hA5); RESET = 1'b0; NXT = 1'b0;
      step(); chk("mrst_dout", ulpi_dout, 8'h00); chk("mrst_stp", STP, 0); chk("mrst_busy", busy, 0);
      chk("mrst_ack", bus.reg_ack, 0);
      RESET = 1'b1; bus.reg_req = 1'b0;
      step(); chk("mrst_ack_after", bus.reg_ack, 0); chk("mrst_busy_after", busy, 0);

`ifdef ULPI_ARB_TIMEOUT_EN
      // Write with NXT held low: eight cycles in REG_CMD, STP pulse, then ack with error.
      bus.reg_req = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = 6'h0A; bus.reg_wdata = 8'h00;
      step(); chk("to_cmd", ulpi_dout, 8'h8A);
      for (int i = 0; i < 7; i++) begin
         step(); chk("to_wait_dout", ulpi_dout, 8'h8A); chk("to_wait_stp", STP, 0);
      end
      step(); chk("to_stp", STP, 1); chk("to_stp_dout", ulpi_dout, 8'h00);
      step(); chk("to_ack", bus.reg_ack, 1); chk("to_err", bus.reg_err, 1); chk("to_stp_low", STP, 0);
      bus.reg_req = 1'b0;
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
